// File: rtl/ln_pkg.sv
// Shared constants and types for the ln unit: exponent bias, LUT address and mantissa widths,
// input fraction width and the Q4.11 fixed-point word used by the LUT and the downstream adder.
package ln_pkg;
  localparam int LN_EXP_BIAS = 15;
  localparam int LN_ADDR_W   = 5;
  localparam int LN_MANT_W   = 11;
  localparam int LN_FRAC_IN  = 15;

  typedef logic signed [15:0] ln_q4_11_t;
endpackage

// File: rtl/ln_normalize_if.sv
// Input and output valid/ready streams of ln_normalize; slave is the block, master drives operands.
interface ln_normalize_if
  import ln_pkg::*;
#(
  parameter int DIN_W  = 1 << LN_ADDR_W,
  parameter int MANT_W = LN_MANT_W,
  parameter int TAG_W  = 4
);
  localparam int ADDR_W = $clog2(DIN_W);

  logic              in_valid;
  logic              in_ready;
  logic [DIN_W-1:0]  in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [MANT_W-1:0] out_mant;
  logic              out_zero;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_addr, out_mant, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_addr, out_mant, out_zero, out_tag
  );
endinterface

// File: rtl/ln_lod32.sv
// Combinational leading-one detector: position of the most significant set bit plus an all-zero flag.
module ln_lod32
  import ln_pkg::*;
#(
  parameter int DIN_W = 1 << LN_ADDR_W,
  localparam int ADDR_W = $clog2(DIN_W)
) (
  input  logic [DIN_W-1:0]  din,
  output logic [ADDR_W-1:0] pos,
  output logic              zero
);
  // Later (higher) bits overwrite earlier ones, so the last hit is the leading one.
  always_comb begin
    pos = '0;
    for (int i = 0; i < DIN_W; i++) begin
      if (din[i]) pos = ADDR_W'(i);
    end
  end

  assign zero = (din == '0);
endmodule

// File: rtl/ln_normalize.sv
// Range-reduction front end of the ln unit: 2-stage valid/ready pipeline producing LUT exponent and
// Q0.MANT_W mantissa. Define LN_NORM_ROUND_EN for round-to-nearest mantissa (default: truncate).
module ln_normalize
  import ln_pkg::*;
#(
  parameter int DIN_W  = 32,
  parameter int FRAC_W = LN_FRAC_IN,
  parameter int MANT_W = LN_MANT_W,
  parameter int TAG_W  = 4
) (
  input logic          clk,
  input logic          rst,
  ln_normalize_if.slave bus
);
  localparam int ADDR_W = $clog2(DIN_W);
  localparam int E_MAX  = (1 << ADDR_W) - 1;

  logic              s1_valid, s2_valid;
  logic [DIN_W-1:0]  s1_data;
  logic [TAG_W-1:0]  s1_tag;
  logic [ADDR_W-1:0] s1_pos;
  logic              s1_zero;
  logic [ADDR_W-1:0] lod_pos;
  logic              lod_zero;

  logic [ADDR_W-1:0] out_addr_q;
  logic [MANT_W-1:0] out_mant_q;
  logic              out_zero_q;
  logic [TAG_W-1:0]  out_tag_q;

  logic              s1_adv, s2_adv;
  logic [ADDR_W-1:0] sh;
  logic [DIN_W-1:0]  norm;
  logic [ADDR_W-1:0] e_clamp, addr_n;
  logic [MANT_W-1:0] mant_n;
  int                e_int;
  logic              unused_norm;

  ln_lod32 #(.DIN_W(DIN_W)) u_lod (
    .din  (bus.in_data),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  assign sh          = ADDR_W'(DIN_W - 1) - s1_pos;
  assign norm        = s1_data << sh;
  assign unused_norm = ^norm;

  always_comb begin
    e_int = int'(s1_pos) - FRAC_W + LN_EXP_BIAS;
    if (e_int < 0)          e_clamp = '0;
    else if (e_int > E_MAX) e_clamp = ADDR_W'(E_MAX);
    else                    e_clamp = ADDR_W'(e_int);
    addr_n = e_clamp;
    mant_n = norm[DIN_W-2 -: MANT_W];
`ifdef LN_NORM_ROUND_EN
    begin
      logic [MANT_W:0] mant_rnd;
      mant_rnd = {1'b0, mant_n} + (MANT_W+1)'(norm[DIN_W-2-MANT_W]);
      // Mantissa overflow renormalises into the next octave unless the LUT is already at its top.
      if (mant_rnd[MANT_W]) begin
        if (e_clamp == ADDR_W'(E_MAX)) begin
          mant_n = '1;
        end else begin
          mant_n = '0;
          addr_n = e_clamp + ADDR_W'(1);
        end
      end else begin
        mant_n = mant_rnd[MANT_W-1:0];
      end
    end
`endif
    if (s1_zero) begin
      addr_n = '0;
      mant_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_tag     <= '0;
      s1_pos     <= '0;
      s1_zero    <= 1'b0;
      s2_valid   <= 1'b0;
      out_addr_q <= '0;
      out_mant_q <= '0;
      out_zero_q <= 1'b0;
      out_tag_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_data <= bus.in_data;
          s1_tag  <= bus.in_tag;
          s1_pos  <= lod_pos;
          s1_zero <= lod_zero;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_addr_q <= addr_n;
          out_mant_q <= mant_n;
          out_zero_q <= s1_zero;
          out_tag_q  <= s1_tag;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_mant  = out_mant_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_ln_normalize.sv
// Self-checking bench for ln_normalize: directed corner cases plus a random stream with random
// backpressure, scored against an arithmetic reference of the normalisation.
module tb_ln_normalize;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  // {tag, zero, addr, mant}
  logic [20:0] q[$];
  logic [3:0]  popped_tags[$];

  ln_normalize_if #(.DIN_W(32), .MANT_W(11), .TAG_W(4)) bus ();

  ln_normalize dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Value = v * 2^-15; exponent E equals the leading-one index for FRAC_W=15.
  function automatic logic [20:0] model(input logic [31:0] v, input logic [3:0] tag);
    int     p;
    int     e;
    longint frac;
    longint m;
    if (v == 32'd0) return {tag, 1'b1, 5'd0, 11'd0};
    p = 31;
    while (v[p] == 1'b0) p--;
    frac = longint'(v) - (longint'(1) << p);
    e = p;
`ifdef LN_NORM_ROUND_EN
    m = (((frac << 12) >> p) + 1) >> 1;
    if (m == 2048) begin
      if (e == 31) m = 2047;
      else begin
        e = e + 1;
        m = 0;
      end
    end
`else
    m = (frac << 11) >> p;
`endif
    return {tag, 1'b0, 5'(e), 11'(m)};
  endfunction

  function automatic logic [20:0] observed();
    return {bus.out_tag, bus.out_zero, bus.out_addr, bus.out_mant};
  endfunction

  // One clock: score handshakes at the falling edge, then advance to just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      chk("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("out_valid_no_pending", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("stream", 32'(observed()), 32'(q[0]));
          if (bus.out_ready) begin
            popped_tags.push_back(q[0][20:17]);
            void'(q.pop_front());
          end
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_data, bus.in_tag));
    end
    @(posedge clk);
    #1;
    if (rst) q.delete();
  endtask

  task automatic single(input string name, input logic [31:0] d, input logic [3:0] t,
                        input logic [4:0] ea, input logic [10:0] em, input logic ez);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_tag    = t;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    chk({name, "_early"}, 32'(bus.out_valid), 32'd0);
    step();
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_addr"}, 32'(bus.out_addr), 32'(ea));
    chk({name, "_mant"}, 32'(bus.out_mant), 32'(em));
    chk({name, "_zero"}, 32'(bus.out_zero), 32'(ez));
    chk({name, "_tag"}, 32'(bus.out_tag), 32'(t));
    step();
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 50;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk({name, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_out_mant", 32'(bus.out_mant), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    rst = 1'b0;
    step();

    single("one", 32'h0000_8000, 4'h5, 5'd15, 11'h000, 1'b0);
    single("three", 32'h0001_8000, 4'h6, 5'd16, 11'h400, 1'b0);
    single("lsb", 32'h0000_0001, 4'h7, 5'd0, 11'h000, 1'b0);
    single("zero", 32'h0000_0000, 4'hA, 5'd0, 11'h000, 1'b1);
`ifdef LN_NORM_ROUND_EN
    single("ffff", 32'h0000_FFFF, 4'h3, 5'd16, 11'h000, 1'b0);
    single("max", 32'hFFFF_FFFF, 4'hC, 5'd31, 11'h7FF, 1'b0);
`else
    single("ffff", 32'h0000_FFFF, 4'h3, 5'd15, 11'h7FF, 1'b0);
    single("max", 32'hFFFF_FFFF, 4'hC, 5'd31, 11'h7FF, 1'b0);
`endif

    // Backpressure: three offered, two held, third waits; then release in order.
    popped_tags.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      bus.in_tag  = 4'(t);
      bus.in_data = $urandom;
      while (!bus.in_ready && bus.out_ready) step();
      if (t == 3) begin
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_inflight", 32'(q.size()), 32'd2);
        for (int k = 0; k < 3; k++) step();
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
      end
      step();
    end
    drain("stall");
    chk("order_count", 32'(popped_tags.size()), 32'd3);
    if (popped_tags.size() == 3) begin
      chk("order_0", 32'(popped_tags[0]), 32'd1);
      chk("order_1", 32'(popped_tags[1]), 32'd2);
      chk("order_2", 32'(popped_tags[2]), 32'd3);
    end

    // Reset with two values in flight: nothing stale may surface afterwards.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0001_2345;
    step();
    bus.in_data   = 32'h0100_0000;
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_inflight", 32'(q.size()), 32'd2);
    rst = 1'b1;
    step();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("mid_rst_out_mant", 32'(bus.out_mant), 32'd0);
    chk("mid_rst_out_zero", 32'(bus.out_zero), 32'd0);
    chk("mid_rst_out_tag", 32'(bus.out_tag), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Random stream with random backpressure and operand magnitudes.
    for (int k = 0; k < 1500; k++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_tag    = 4'($urandom);
      bus.in_data   = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
